bcd_step_counter: RTL and testbench
===================================

# bcd_step_counter

Three-digit BCD up/down counter that turns the board push-buttons into stable digit values. Each clean press moves the count by one. It sits directly upstream of the LED matrix display driver and the seven-segment hex decoders. Its digit outputs are wired straight to those consumers' 4-bit digit inputs, so every output is a registered, glitch-free BCD nibble in the range 0–9.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000 — number of consecutive stable cycles (10 ms at 50 MHz) before a button level is accepted; legal range ≥ 2.

Ports:
- CLOCK_50  input  1  — system clock; all logic on its rising edge.
- resetn  input  1  — one clock; reset is synchronous and active-low. All state is reset on a rising edge with resetn = 0.
- enable  input  1  — when 0, step requests are discarded; debouncers keep running.
- clear  input  1  — level, active-high; forces count to 000 while asserted.
- inc_n  input  1  — raw increment button, active-low, asynchronous to CLOCK_50.
- dec_n  input  1  — raw decrement button, active-low, asynchronous to CLOCK_50.
- digit0  output  4  — BCD ones digit.
- digit1  output  4  — BCD tens digit.
- digit2  output  4  — BCD hundreds digit.
- wrap  output  1  — one-cycle pulse when an increment goes 999→000.
- borrow  output  1  — one-cycle pulse when a decrement goes 000→999.

## Operation
- **Synchroniser:** each raw button passes through a 2-FF synchroniser; both FFs reset to 1.
- **Debouncer:** one per button. It keeps an accepted level (reset 1) and a stability counter (reset 0).
  - If the synchronised value equals the accepted level, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 while the value still differs, the accepted level flips and the counter is cleared.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- **Press detect:** a 1→0 transition of the accepted level produces a one-cycle request (inc_req or dec_req). A release produces no request.
- **Update priority**, evaluated each cycle:
  1. clear = 1: count ← 000; wrap and borrow = 0; requests dropped.
  2. enable = 0: count held; requests dropped, not queued.
  3. inc_req and dec_req in the same cycle: they cancel; no change, no pulse.
  4. inc_req only: BCD increment. digit0 carries into digit1 at 9→0, and digit1 into digit2. At 999 the count becomes 000 and wrap is asserted for one cycle.
  5. dec_req only: BCD decrement with borrow chain. At 000 the count becomes 999 and borrow is asserted for one cycle.
- No digit ever holds a value of 10–15.
- Holding a button produces exactly one step. There is no auto-repeat.

## Timing
- **Reset values:** digit0/1/2 = 0, wrap = 0, borrow = 0, accepted levels = 1, counters = 0.
- **Latency:** raw button change to debounced level flip is 2 + DEBOUNCE_CYCLES cycles. The digits update on the following edge. Total from the raw change to the new digit value is DEBOUNCE_CYCLES + 3 cycles.
- **wrap / borrow:** registered, and asserted in the same cycle as the digit change they describe.
- **Glitches:** a raw glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets the stability counter and produces no request.
- **Reset mid-debounce:** reset while a button is held clears the debouncer. A still-held button is then accepted as a new press DEBOUNCE_CYCLES + 2 cycles after resetn deasserts, producing one step.
- **clear deassert:** counting resumes on the next cycle with the count at 000. A request arriving in the cycle clear falls is honoured.

## Configuration
- BCD_STEP_SATURATE_EN defined: the count saturates instead of wrapping.
  - Increment at 999 leaves 999.
  - Decrement at 000 leaves 000.
  - wrap and borrow are tied to 0.
- BCD_STEP_SATURATE_EN undefined (default): wrap-around behaviour as described in Operation.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset, single press:** hold resetn = 0 for 3 cycles, then release; drive inc_n low for 20 cycles. Digits read 0,0,0 after reset. digit0 becomes 1 exactly 7 cycles after inc_n falls and stays 1; wrap stays 0.
- **Glitch rejection:** pulse inc_n low for 3 cycles. Count unchanged.
- **Carry chain and wrap:** preload 099 with 99 presses; one more inc gives 100. Preload 999; one inc gives 000 with wrap high for exactly one cycle. With BCD_STEP_SATURATE_EN defined, the count stays 999 and wrap stays 0.
- **Borrow:** from 000, one dec press gives 999 with borrow pulsed once. From 100, one dec press gives 099.
- **Simultaneous and gated requests:** press inc_n and dec_n on the same cycle; count unchanged. With enable = 0, press inc; count unchanged, and raising enable later does not apply the dropped step.
- **Priority and reset mid-press:** assert clear during an inc press at 057; count becomes 000 with no pulse. Then assert reset while inc_n is held low; after resetn = 1, count reads 001 after DEBOUNCE_CYCLES + 3 cycles.

Source files
------------

// File: rtl/bcd_step_counter.sv
// Three-digit BCD up/down counter driven by debounced inc/dec push-buttons.
// Define BCD_STEP_SATURATE_EN to saturate at 000/999 instead of wrapping.
module bcd_step_counter #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       enable,
   input  logic       clear,
   input  logic       inc_n,
   input  logic       dec_n,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic       wrap,
   output logic       borrow
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Button index 0 is increment, 1 is decrement.
   logic [1:0]            raw;
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            lvl_q, lvl_d, lvl_prev_q;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            req;
   logic [11:0]           count_q, count_d;
   logic                  wrap_q, wrap_d;
   logic                  borrow_q, borrow_d;

   assign raw = {dec_n, inc_n};

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic c;
      c = 1'b1;
      bcd_inc = v;
      for (int i = 0; i < 3; i++) begin
         if (c) begin
            if (v[i*4 +: 4] == 4'd9) begin
               bcd_inc[i*4 +: 4] = 4'd0;
            end else begin
               bcd_inc[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
   endfunction

   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic b;
      b = 1'b1;
      bcd_dec = v;
      for (int i = 0; i < 3; i++) begin
         if (b) begin
            if (v[i*4 +: 4] == 4'd0) begin
               bcd_dec[i*4 +: 4] = 4'd9;
            end else begin
               bcd_dec[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
   endfunction

   // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] == lvl_q[b]) begin
            cnt_d[b] = '0;
         end else if (cnt_q[b] == CNT_LAST) begin
            lvl_d[b] = ~lvl_q[b];
            cnt_d[b] = '0;
         end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
         end
      end
   end

   assign req = lvl_prev_q & ~lvl_q;

   always_comb begin
      count_d  = count_q;
      wrap_d   = 1'b0;
      borrow_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (enable && (req[0] ^ req[1])) begin
         if (req[0]) begin
`ifdef BCD_STEP_SATURATE_EN
            if (count_q != 12'h999) count_d = bcd_inc(count_q);
`else
            count_d = bcd_inc(count_q);
            wrap_d  = (count_q == 12'h999);
`endif
         end else begin
`ifdef BCD_STEP_SATURATE_EN
            if (count_q != 12'h000) count_d = bcd_dec(count_q);
`else
            count_d  = bcd_dec(count_q);
            borrow_d = (count_q == 12'h000);
`endif
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         lvl_q      <= '1;
         lvl_prev_q <= '1;
         cnt_q      <= '0;
         count_q    <= '0;
         wrap_q     <= 1'b0;
         borrow_q   <= 1'b0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
         cnt_q      <= cnt_d;
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         borrow_q   <= borrow_d;
      end
   end

   assign digit0 = count_q[3:0];
   assign digit1 = count_q[7:4];
   assign digit2 = count_q[11:8];
   assign wrap   = wrap_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed, table-driven bench for bcd_step_counter with DEBOUNCE_CYCLES = 4.
module tb_bcd_step_counter;
   localparam int D = 4;
`ifdef BCD_STEP_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0, enable = 1'b1, clear = 1'b0, inc_n = 1'b1, dec_n = 1'b1;
   logic [3:0] digit0, digit1, digit2;
   logic       wrap, borrow;

   int checks = 0, errors = 0;
   int wcnt = 0, bcnt = 0;

   bcd_step_counter #(.DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_50(clk), .resetn(resetn), .enable(enable), .clear(clear),
      .inc_n(inc_n), .dec_n(dec_n),
      .digit0(digit0), .digit1(digit1), .digit2(digit2),
      .wrap(wrap), .borrow(borrow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        inc;
      logic        dec;
      logic        en;
      logic        clr;
      int          low;
      logic [11:0] exp;
      int          expw;
      int          expb;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [11:0] cnt();
      return {digit2, digit1, digit0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (wrap === 1'b1) wcnt++;
      if (borrow === 1'b1) bcnt++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic i, input logic d, input int low);
      inc_n = ~i;
      dec_n = ~d;
      repeat (low) tick();
      inc_n = 1'b1;
      dec_n = 1'b1;
      repeat (D + 3) tick();
   endtask

   task automatic clr_pulse();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, D+3, SAT ? 12'h000 : 12'h999, 0, SAT ? 0 : 1};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, D+3, SAT ? 12'h001 : 12'h000, SAT ? 0 : 1, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, D+3, SAT ? 12'h002 : 12'h001, 0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, D+3, SAT ? 12'h002 : 12'h001, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, D+3, SAT ? 12'h002 : 12'h001, 0, 0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, D-1, SAT ? 12'h002 : 12'h001, 0, 0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, D+3, SAT ? 12'h001 : 12'h000, 0, 0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, D+3, 12'h000, 0, 0};

      // Reset state and single-press latency
      repeat (3) tick();
      chk("reset_count", cnt(), 12'h000);
      chk("reset_wrap", wrap, 1'b0);
      chk("reset_borrow", borrow, 1'b0);
      resetn = 1'b1;
      wcnt = 0;
      inc_n = 1'b0;
      repeat (D + 2) tick();
      chk("latency_before", cnt(), 12'h000);
      tick();
      chk("latency_at", cnt(), 12'h001);
      repeat (13) tick();
      chk("held_one_step", cnt(), 12'h001);
      chk("held_no_wrap", wcnt, 0);
      inc_n = 1'b1;
      repeat (D + 3) tick();

      // Table-driven single presses
      clr_pulse();
      for (int k = 0; k < 8; k++) begin
         wcnt = 0;
         bcnt = 0;
         enable = tbl[k].en;
         clear = tbl[k].clr;
         press(tbl[k].inc, tbl[k].dec, tbl[k].low);
         enable = 1'b1;
         clear = 1'b0;
         tick();
         chk($sformatf("vec%0d_count", k), cnt(), tbl[k].exp);
         chk($sformatf("vec%0d_wrap", k), wcnt, tbl[k].expw);
         chk($sformatf("vec%0d_borrow", k), bcnt, tbl[k].expb);
      end

      // Carry chain, borrow chain, top-end wrap
      clr_pulse();
      repeat (99) press(1'b1, 1'b0, D + 3);
      chk("preload_099", cnt(), 12'h099);
      press(1'b1, 1'b0, D + 3);
      chk("carry_100", cnt(), 12'h100);
      bcnt = 0;
      press(1'b0, 1'b1, D + 3);
      chk("borrow_chain_099", cnt(), 12'h099);
      chk("borrow_chain_nopulse", bcnt, 0);
      repeat (900) press(1'b1, 1'b0, D + 3);
      chk("preload_999", cnt(), 12'h999);
      wcnt = 0;
      press(1'b1, 1'b0, D + 3);
      chk("wrap_count", cnt(), SAT ? 12'h999 : 12'h000);
      chk("wrap_pulses", wcnt, SAT ? 0 : 1);

      // Dropped request is not replayed when enable returns
      clr_pulse();
      enable = 1'b0;
      inc_n = 1'b0;
      repeat (10) tick();
      enable = 1'b1;
      repeat (5) tick();
      chk("gated_held", cnt(), 12'h000);
      inc_n = 1'b1;
      repeat (D + 3) tick();
      chk("gated_released", cnt(), 12'h000);
      press(1'b1, 1'b0, D + 3);
      chk("gated_then_step", cnt(), 12'h001);

      // Clear overrides a press at 057
      clr_pulse();
      repeat (57) press(1'b1, 1'b0, D + 3);
      chk("preload_057", cnt(), 12'h057);
      wcnt = 0;
      bcnt = 0;
      inc_n = 1'b0;
      repeat (4) tick();
      clear = 1'b1;
      repeat (5) tick();
      clear = 1'b0;
      tick();
      chk("clear_priority", cnt(), 12'h000);
      inc_n = 1'b1;
      repeat (D + 3) tick();
      chk("clear_no_pulse", wcnt + bcnt, 0);

      // Reset while the button is held
      inc_n = 1'b0;
      repeat (10) tick();
      resetn = 1'b0;
      repeat (2) tick();
      chk("midpress_reset", cnt(), 12'h000);
      resetn = 1'b1;
      repeat (D + 2) tick();
      chk("midpress_before", cnt(), 12'h000);
      tick();
      chk("midpress_step", cnt(), 12'h001);
      repeat (6) tick();
      chk("midpress_single", cnt(), 12'h001);
      inc_n = 1'b1;
      repeat (D + 3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
